ext_alu_muldiv: RTL and testbench
=================================

Name: ext_alu_muldiv

Overview:
- Multicycle external ALU in the EX stage for signed 32-bit MUL, MULH, DIV and REM.
- Stalls the pipeline while it computes.
- Its registered result feeds dst_ext_EX_DM through the EX/DM latch into the write-back select, which is chosen when ext_alu is set.
- Radix-2 iterative datapath: one result bit per cycle.

Parameters:
- DATA_W, 32: operand/result width. Iteration count equals DATA_W; only 32 is verified.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  ext-ALU instruction present in EX (ext_alu_ID_EX qualified by valid)
- flush  input  1  EX-stage flush (taken branch/jump); aborts an operation in progress
- op  input  2  operation: 00 MUL (low word), 01 MULH (signed high word), 10 DIV (signed quotient), 11 REM (signed remainder)
- src0  input  DATA_W  operand A / dividend
- src1  input  DATA_W  operand B / divisor
- stall_ext  output  1  hold PC, IF/ID and ID/EX; bubble into EX/DM
- done  output  1  single-cycle pulse; result valid
- dst_ext  output  DATA_W  registered result; goes to dst_ext_EX_DM
- div0  output  1  sticky-until-next-op flag: last DIV/REM had src1 == 0

Behaviour:
- Reset (async, rst_n low): state = IDLE; count = 0; dst_ext = 0; div0 = 0; done = 0. stall_ext is driven low by the state decode.
- Reset mid-operation: the operation is discarded; no done pulse is produced.
- State machine IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - stall_ext = start (combinational), so the launching cycle itself stalls.
  - On a clock edge with start=1 and flush=0: latch op, sign flags and |src0|, |src1|; clear the accumulator; count = 0; go to CALC.
- CALC:
  - stall_ext = 1.
  - MUL/MULH: shift-add on magnitudes into a 64-bit accumulator.
  - DIV/REM: restoring shift-subtract producing quotient and remainder.
  - count increments every edge. On the edge where count == DATA_W-1, apply the sign correction, write dst_ext and go to DONE.
- DONE:
  - done = 1 and stall_ext = 0, so the instruction advances with its result.
  - start is ignored in DONE.
  - The next edge always returns to IDLE.
  - A start seen in IDLE after that is a new (back-to-back) instruction.
- Latency: launch in cycle T. stall_ext is high for cycles T..T+32 (33 cycles). done is high in cycle T+33. dst_ext is valid from T+33 and held until the next completed operation.
- Sign rules:
  - Product is negated when sign(src0) != sign(src1).
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero:
  - quotient = 0xFFFFFFFF; remainder = src0.
  - div0 = 1.
  - Latency is unchanged (full 32 iterations).
- Overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. No exception is raised.
- div0 is cleared on every new launch and set at completion of a DIV/REM with a zero divisor.
- flush:
  - Highest priority.
  - In CALC: state goes to IDLE on the next edge, and dst_ext and div0 keep their old values.
  - In IDLE: flush=1 suppresses a launch.
  - In DONE: no effect.
  - stall_ext still follows the current-cycle state decode.
- The operand latch is captured only at launch. Changes on src0/src1/op during CALC have no effect.

Test Plan:
- MUL: src0=7, src1=0xFFFFFFFD (-3) -> stall_ext high for exactly 33 cycles, then done for 1 cycle, dst_ext=0xFFFFFFEB, div0=0.
- MULH: 0x80000000 x 0x80000000 -> dst_ext=0x40000000. Also 0xFFFFFFFF x 5 -> dst_ext=0xFFFFFFFF.
- DIV/REM: -7 / 2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF. 7 / -2 -> DIV 0xFFFFFFFD, REM 0x00000001.
- Divide corner cases:
  - DIV 0x12345678 / 0 -> dst_ext=0xFFFFFFFF, div0=1.
  - REM of the same operands -> dst_ext=0x12345678.
  - DIV 0x80000000 / -1 -> dst_ext=0x80000000.
- Back-to-back: start held high across two MULs (3x4, then 5x6) -> two done pulses 34 cycles apart, dst_ext 12 then 30. start during DONE does not relaunch.
- Abort and reset:
  - flush in CALC cycle 10 -> IDLE next edge, no done, dst_ext retains the previous value.
  - rst_n low mid-CALC -> immediately IDLE, dst_ext=0, stall_ext=0.

Source files
------------

// File: rtl/ext_alu_muldiv_if.sv
// rtl/ext_alu_muldiv_if.sv - EX-stage handshake bundle between the pipeline and the external mul/div ALU
//
// Purpose: groups the launch/abort controls, operands and result/status of the
//          external ALU so the pipeline and the ALU connect through one port.
// Signals:
//   start      pipeline -> alu  ext-ALU instruction present in EX (qualified by valid)
//   flush      pipeline -> alu  EX-stage flush; aborts an operation in progress
//   op         pipeline -> alu  00 MUL, 01 MULH, 10 DIV, 11 REM (all signed)
//   src0       pipeline -> alu  operand A / dividend
//   src1       pipeline -> alu  operand B / divisor
//   stall_ext  alu -> pipeline  hold PC, IF/ID, ID/EX; bubble into EX/DM
//   done       alu -> pipeline  single-cycle pulse, result valid
//   dst_ext    alu -> pipeline  registered result, feeds dst_ext_EX_DM
//   div0       alu -> pipeline  last DIV/REM had a zero divisor
// Modports: master = pipeline side, slave = ALU side.
interface ext_alu_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              flush;
    logic [1:0]        op;
    logic [DATA_W-1:0] src0;
    logic [DATA_W-1:0] src1;
    logic              stall_ext;
    logic              done;
    logic [DATA_W-1:0] dst_ext;
    logic              div0;

    modport master (
        output start, flush, op, src0, src1,
        input  stall_ext, done, dst_ext, div0
    );

    modport slave (
        input  start, flush, op, src0, src1,
        output stall_ext, done, dst_ext, div0
    );
endinterface

// File: rtl/ext_alu_muldiv.sv
// rtl/ext_alu_muldiv.sv - multicycle radix-2 signed MUL/MULH/DIV/REM unit for the EX stage
//
// Purpose: computes one result bit per cycle on operand magnitudes, applies the
//          sign correction on the final iteration and holds the result in a register.
//          IDLE -> CALC (DATA_W cycles) -> DONE -> IDLE.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ext_alu_muldiv_if.slave (start, flush, op, src0, src1 in;
//          stall_ext, done, dst_ext, div0 out)
module ext_alu_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ext_alu_muldiv_if.slave       bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                launch;
    logic                last;

    logic [CNT_W-1:0]    count;
    logic [1:0]          op_q;
    logic                neg_a;
    logic                neg_b;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   dst_q;
    logic                div0_q;

    logic [DATA_W-1:0]   src0_mag;
    logic [DATA_W-1:0]   src1_mag;
    logic [CNT_W-1:0]    bit_idx;
    logic [DATA_W:0]     rem_shift;
    logic                rem_ge;
    logic [DATA_W-1:0]   rem_trial;
    logic [2*DATA_W-1:0] acc_next;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic                b_zero;
    logic [DATA_W-1:0]   result;

    assign src0_mag = bus.src0[DATA_W-1] ? -bus.src0 : bus.src0;
    assign src1_mag = bus.src1[DATA_W-1] ? -bus.src1 : bus.src1;
    assign last     = (state == CALC) && (count == CNT_W'(DATA_W - 1));
    assign b_zero   = (b_mag == '0);

    // flush has priority over both launch and completion
    always_comb begin
        state_next    = state;
        launch        = 1'b0;
        bus.stall_ext = 1'b0;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.stall_ext = bus.start;
                if (bus.start && !bus.flush) begin
                    state_next = CALC;
                    launch     = 1'b1;
                end
            end
            CALC: begin
                bus.stall_ext = 1'b1;
                if (bus.flush)
                    state_next = IDLE;
                else if (last)
                    state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One iteration. MUL walks the multiplier MSB-first so the accumulator
    // only ever shifts left. DIV keeps {remainder, dividend/quotient} in acc:
    // the dividend shifts out of the low half as quotient bits shift in.
    always_comb begin
        bit_idx   = CNT_W'(DATA_W - 1) - count;
        rem_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        rem_ge    = rem_shift >= {1'b0, b_mag};
        rem_trial = rem_ge ? DATA_W'(rem_shift - {1'b0, b_mag}) : rem_shift[DATA_W-1:0];
        if (op_q[1])
            acc_next = {rem_trial, acc[DATA_W-2:0], rem_ge};
        else
            acc_next = {acc[2*DATA_W-2:0], 1'b0}
                     + ({(2*DATA_W){b_mag[bit_idx]}} & {{DATA_W{1'b0}}, a_mag});
    end

    // Sign correction on the value the final iteration produces. A zero
    // divisor makes every trial subtract succeed, so the remainder already
    // equals |src0|; the quotient is forced to all ones regardless of sign.
    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc_next : acc_next;
        quo  = acc_next[DATA_W-1:0];
        rem  = acc_next[2*DATA_W-1:DATA_W];
        case (op_q)
            2'b00:   result = prod[DATA_W-1:0];
            2'b01:   result = prod[2*DATA_W-1:DATA_W];
            2'b10:   result = b_zero ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
            default: result = neg_a ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            op_q   <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            acc    <= '0;
            dst_q  <= '0;
            div0_q <= 1'b0;
        end else begin
            state <= state_next;
            if (launch) begin
                op_q   <= bus.op;
                neg_a  <= bus.src0[DATA_W-1];
                neg_b  <= bus.src1[DATA_W-1];
                a_mag  <= src0_mag;
                b_mag  <= src1_mag;
                acc    <= bus.op[1] ? {{DATA_W{1'b0}}, src0_mag} : '0;
                count  <= '0;
                div0_q <= 1'b0;
            end else if (state == CALC && !bus.flush) begin
                acc   <= acc_next;
                count <= count + CNT_W'(1);
                if (last) begin
                    dst_q  <= result;
                    div0_q <= op_q[1] && b_zero;
                end
            end
        end
    end

    assign bus.dst_ext = dst_q;
    assign bus.div0    = div0_q;
endmodule

// File: tb/tb_ext_alu_muldiv.sv
// tb/tb_ext_alu_muldiv.sv - directed self-checking bench for ext_alu_muldiv
module tb_ext_alu_muldiv;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ext_alu_muldiv_if #(.DATA_W(32)) bus ();

    ext_alu_muldiv #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one op, scramble the inputs during CALC, count stall cycles up to done.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic exp_div0);
        int n_stall;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src0 = a; bus.src1 = b;
        #1;
        check({tag, " launch_stall"}, 32'(bus.stall_ext), 32'd1);
        n_stall = 1;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.op = ~op; bus.src0 = ~a; bus.src1 = 32'h0;
            #1;
            if (bus.done) seen = 1'b1;
            else if (bus.stall_ext) n_stall++;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " stall_cycles"}, 32'(n_stall), 32'd33);
        check({tag, " stall_at_done"}, 32'(bus.stall_ext), 32'd0);
        check({tag, " dst_ext"}, bus.dst_ext, exp);
        check({tag, " div0"}, 32'(bus.div0), 32'(exp_div0));
        @(negedge clk);
        #1;
        check({tag, " done_pulse_width"}, 32'(bus.done), 32'd0);
        check({tag, " dst_held"}, bus.dst_ext, exp);
    endtask

    initial begin
        int gap;
        int n_done;
        bit seen;

        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
        bus.src0 = 32'h0; bus.src1 = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset stall_ext", 32'(bus.stall_ext), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset dst_ext", bus.dst_ext, 32'd0);
        check("reset div0", 32'(bus.div0), 32'd0);
        rst_n = 1'b1;

        run_op("mul 7x-3",       2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mulh min*min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        run_op("mulh -1x5",      2'b01, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 1'b0);
        run_op("div -7/2",       2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        run_op("rem -7/2",       2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
        run_op("div 7/-2",       2'b10, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
        run_op("rem 7/-2",       2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("div by zero",    2'b10, 32'h12345678, 32'h0,        32'hFFFFFFFF, 1'b1);
        run_op("rem by zero",    2'b11, 32'h12345678, 32'h0,        32'h12345678, 1'b1);
        run_op("div overflow",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_op("rem overflow",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);

        // back-to-back: start held across DONE; DONE must not relaunch
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.src0 = 32'd3; bus.src1 = 32'd4;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check("b2b first done", 32'(seen), 32'd1);
        check("b2b first dst", bus.dst_ext, 32'd12);
        bus.src0 = 32'd5; bus.src1 = 32'd6;
        seen = 1'b0;
        gap  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            gap++;
            if (bus.done) seen = 1'b1;
        end
        check("b2b second done", 32'(seen), 32'd1);
        check("b2b done spacing", 32'(gap), 32'd34);
        check("b2b second dst", bus.dst_ext, 32'd30);
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        check("b2b idle after", 32'(bus.stall_ext), 32'd0);

        // flush in IDLE suppresses the launch
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.src0 = 32'd9; bus.src1 = 32'd9;
        #1;
        check("flush idle stall", 32'(bus.stall_ext), 32'd1);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        check("flush idle no launch", 32'(bus.stall_ext), 32'd0);

        // flush in CALC cycle 10
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.src0 = 32'd9; bus.src1 = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush calc stall", 32'(bus.stall_ext), 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush back to idle", 32'(bus.stall_ext), 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("flush no done", 32'(n_done), 32'd0);
        check("flush dst kept", bus.dst_ext, 32'd30);

        // reset in the middle of CALC
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.src0 = 32'd9; bus.src1 = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset stall_ext", 32'(bus.stall_ext), 32'd0);
        check("midreset dst_ext", bus.dst_ext, 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("midreset no done", 32'(n_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
